// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - control FSM sequencing the 16-bit multi-cycle datapath
module multicycle_ctrl_fsm #(
    parameter int OPCODE_W    = 4,
    parameter int STATE_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                ir_en,
    output logic                ab_en,
    output logic                aluout_en,
    output logic                mdr_en,
    output logic                rf_we,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                iord,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                rf_dst,
    output logic                wb_sel,
    output logic                halted,
    output logic                err,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEM_ADDR = STATE_W'(2),
        MEM_RD   = STATE_W'(3),
        MEM_WB   = STATE_W'(4),
        MEM_WR   = STATE_W'(5),
        EXEC_R   = STATE_W'(6),
        EXEC_I   = STATE_W'(7),
        ALU_WB   = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        JUMP     = STATE_W'(10),
        HALT     = STATE_W'(11)
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

    state_t     state_q;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       rf_dst_q;
    logic       waiting;
    logic       timeout;
    logic       bad_state;

    assign state  = state_q;
    assign halted = (state_q == HALT);

    always_comb begin
        nxt       = state_q;
        bad_state = 1'b0;
        timeout   = 1'b0;
        waiting   = (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR) && !mem_ready;
        case (state_q)
            FETCH:    if (mem_ready) nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:          nxt = EXEC_R;
                    OP_ADDI:       nxt = EXEC_I;
                    OP_LW, OP_SW:  nxt = MEM_ADDR;
                    OP_BEQ:        nxt = BRANCH;
                    OP_JMP:        nxt = JUMP;
                    OP_HALT:       nxt = HALT;
                    default:       nxt = HALT;
                endcase
            end
            MEM_ADDR: nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) nxt = MEM_WB;
            MEM_WR:   if (mem_ready) nxt = FETCH;
            EXEC_R, EXEC_I:                 nxt = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JUMP:   nxt = FETCH;
            HALT:     nxt = HALT;
            default: begin
                nxt       = HALT;
                bad_state = 1'b1;
            end
        endcase
        // The counter reaching the limit on this stall cycle turns it into an error halt
        if (waiting && (wait_cnt + 8'd1) == 8'(MEM_TIMEOUT)) begin
            nxt     = HALT;
            timeout = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
            rf_dst_q <= 1'b0;
        end else begin
            state_q <= nxt;
            if (nxt != state_q)
                wait_cnt <= 8'd0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout || bad_state)
                err <= 1'b1;
            if (state_q == EXEC_R)
                rf_dst_q <= 1'b1;
            else if (state_q == EXEC_I)
                rf_dst_q <= 1'b0;
        end
    end

    always_comb begin
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        ab_en     = 1'b0;
        aluout_en = 1'b0;
        mdr_en    = 1'b0;
        rf_we     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        pc_src    = 2'd0;
        rf_dst    = 1'b0;
        wb_sel    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'd1;
                ir_en     = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                ab_en     = 1'b1;
                aluout_en = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                aluout_en = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                aluout_en = 1'b1;
            end
            ALU_WB: begin
                rf_we  = 1'b1;
                rf_dst = rf_dst_q;
            end
            MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                mdr_en = mem_ready;
            end
            MEM_WB: begin
                rf_we  = 1'b1;
                wb_sel = 1'b1;
            end
            MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_en     = zero;
            end
            JUMP: begin
                pc_src = 2'd2;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts the instruction in flight: nothing may be written this cycle
        if (rst) begin
            pc_en     = 1'b0;
            ir_en     = 1'b0;
            ab_en     = 1'b0;
            aluout_en = 1'b0;
            mdr_en    = 1'b0;
            rf_we     = 1'b0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_rd, mem_wr;
    logic       iord, alu_src_a, rf_dst, wb_sel, halted, err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int mdr_pulses;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPCODE_W(4), .STATE_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .ab_en(ab_en), .aluout_en(aluout_en),
        .mdr_en(mdr_en), .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .rf_dst(rf_dst), .wb_sel(wb_sel), .halted(halted),
        .err(err), .state(state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
        cyc();
        chk("reset_state", 8'(state), 8'd0);
        chk("reset_err", 8'(err), 8'd0);
        chk("reset_pc_en_forced", 8'(pc_en), 8'd0);
        chk("reset_mem_rd_forced", 8'(mem_rd), 8'd0);

        // R-type: 0,1,6,8,0
        rst = 1'b0; #1;
        chk("r_fetch_mem_rd", 8'(mem_rd), 8'd1);
        chk("r_fetch_ir_en", 8'(ir_en), 8'd1);
        chk("r_fetch_alu_src_b", 8'(alu_src_b), 8'd1);
        cyc();
        chk("r_decode_state", 8'(state), 8'd1);
        chk("r_decode_alu_src_b", 8'(alu_src_b), 8'd3);
        chk("r_decode_ab_en", 8'(ab_en), 8'd1);
        chk("r_decode_rf_we", 8'(rf_we), 8'd0);
        cyc();
        chk("r_exec_state", 8'(state), 8'd6);
        chk("r_exec_alu_op", 8'(alu_op), 8'd2);
        chk("r_exec_rf_we", 8'(rf_we), 8'd0);
        cyc();
        chk("r_wb_state", 8'(state), 8'd8);
        chk("r_wb_rf_we", 8'(rf_we), 8'd1);
        chk("r_wb_rf_dst", 8'(rf_dst), 8'd1);
        cyc();
        chk("r_back_fetch", 8'(state), 8'd0);

        // LW with three stall cycles in MEM_RD: 0,1,2,3,3,3,3,4,0
        opcode = 4'd2;
        cyc();
        chk("lw_decode", 8'(state), 8'd1);
        cyc();
        chk("lw_mem_addr", 8'(state), 8'd2);
        chk("lw_addr_src_b", 8'(alu_src_b), 8'd2);
        mdr_pulses = 0;
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk("lw_mem_rd_state", 8'(state), 8'd3);
            chk("lw_mem_rd_iord", 8'(iord), 8'd1);
            mdr_pulses += int'(mdr_en);
            cyc();
        end
        chk("lw_mdr_pulses", 8'(mdr_pulses), 8'd1);
        chk("lw_wb_state", 8'(state), 8'd4);
        chk("lw_wb_sel", 8'(wb_sel), 8'd1);
        chk("lw_wb_rf_we", 8'(rf_we), 8'd1);
        chk("lw_wb_rf_dst", 8'(rf_dst), 8'd0);
        cyc();
        chk("lw_back_fetch", 8'(state), 8'd0);

        // BEQ taken then not taken
        opcode = 4'd4; zero = 1'b1;
        cyc(); cyc();
        chk("beq1_state", 8'(state), 8'd9);
        chk("beq1_pc_en", 8'(pc_en), 8'd1);
        chk("beq1_pc_src", 8'(pc_src), 8'd1);
        chk("beq1_alu_op", 8'(alu_op), 8'd1);
        cyc();
        chk("beq1_fetch", 8'(state), 8'd0);
        zero = 1'b0;
        cyc(); cyc();
        chk("beq0_state", 8'(state), 8'd9);
        chk("beq0_pc_en", 8'(pc_en), 8'd0);
        cyc();
        chk("beq0_fetch", 8'(state), 8'd0);

        // JMP
        opcode = 4'd5;
        cyc(); cyc();
        chk("jmp_state", 8'(state), 8'd10);
        chk("jmp_pc_en", 8'(pc_en), 8'd1);
        chk("jmp_pc_src", 8'(pc_src), 8'd2);
        cyc();
        chk("jmp_fetch", 8'(state), 8'd0);

        // ADDI writes back to rt
        opcode = 4'd1;
        cyc(); cyc();
        chk("addi_exec", 8'(state), 8'd7);
        cyc();
        chk("addi_wb_state", 8'(state), 8'd8);
        chk("addi_wb_rf_dst", 8'(rf_dst), 8'd0);
        cyc();

        // SW stalled, reset mid-write
        opcode = 4'd3;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        chk("sw_mem_wr_state", 8'(state), 8'd5);
        chk("sw_mem_wr", 8'(mem_wr), 8'd1);
        cyc();
        chk("sw_stall_state", 8'(state), 8'd5);
        rst = 1'b1; #1;
        chk("sw_rst_mem_wr", 8'(mem_wr), 8'd0);
        cyc();
        chk("sw_rst_fetch", 8'(state), 8'd0);
        rst = 1'b0; mem_ready = 1'b1;

        // Illegal opcode halts without err
        opcode = 4'd9;
        cyc();
        chk("ill_decode_rf_we", 8'(rf_we), 8'd0);
        chk("ill_decode_mem_wr", 8'(mem_wr), 8'd0);
        cyc();
        chk("ill_halt_state", 8'(state), 8'd11);
        chk("ill_halted", 8'(halted), 8'd1);
        chk("ill_err", 8'(err), 8'd0);
        chk("ill_halt_rf_we", 8'(rf_we), 8'd0);
        cyc();
        chk("ill_halt_sticky", 8'(state), 8'd11);

        // Fetch timeout after 15 stalled cycles
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_ready = 1'b0; opcode = 4'd0;
        repeat (14) cyc();
        chk("to_still_fetch", 8'(state), 8'd0);
        chk("to_no_err_yet", 8'(err), 8'd0);
        cyc();
        chk("to_halt_state", 8'(state), 8'd11);
        chk("to_err", 8'(err), 8'd1);
        chk("to_halted", 8'(halted), 8'd1);
        chk("to_mem_rd_off", 8'(mem_rd), 8'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("to_rst_state", 8'(state), 8'd0);
        chk("to_rst_err", 8'(err), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
